// File: rtl/circuit_pipe.sv
// circuit_pipe: WIDTH-lane F(A,B,C) evaluator, 2-stage valid/ready pipeline (2-cycle latency, stalls
// when out_ready=0) with a built-in 8-vector self-test; `define CIRCUIT_PIPE_PERF_EN adds xfer_cnt.
module circuit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] O,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef CIRCUIT_PIPE_PERF_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  // Bit n is F for the input combination {A,B,C} = n.
  localparam logic [7:0] F_TRUTH = 8'h1A;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic             stream_mode, start_ok, adv, s1_load;
  logic             src_valid, src_test, chk_fail;
  logic [WIDTH-1:0] src_a, src_b, src_c;

  logic             s1_valid, s1_test;
  logic [2:0]       s1_tag;
  logic [WIDTH-1:0] s1_t1, s1_t2;
  logic             s2_valid, s2_test;
  logic [2:0]       s2_tag;

  assign stream_mode = (state == IDLE) || (state == DONE);
  assign start_ok    = start & stream_mode & ~s1_valid & ~s2_valid;
  assign done        = (state == DONE);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    src_test  = 1'b0;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = SWEEP;
      SWEEP: begin
        busy     = 1'b1;
        src_test = 1'b1;
        if (cnt == 3'd7) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt == 3'd1) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The sweep index doubles as the drain-cycle counter; it wraps 7->0 on entering DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 3'd0;
    else if (busy) cnt <= cnt + 3'd1;
    else           cnt <= 3'd0;
  end

  // A start that is being accepted blocks input so no stream vector is trapped behind the sweep.
  assign adv       = busy | ~s2_valid | out_ready;
  assign s1_load   = ~s1_valid | adv;
  assign in_ready  = s1_load & stream_mode & ~start_ok & ~rst;
  assign src_valid = src_test | (in_valid & in_ready);
  assign src_a     = src_test ? {WIDTH{cnt[2]}} : A;
  assign src_b     = src_test ? {WIDTH{cnt[1]}} : B;
  assign src_c     = src_test ? {WIDTH{cnt[0]}} : C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_test  <= 1'b0;
      s1_tag   <= 3'd0;
      s1_t1    <= '0;
      s1_t2    <= '0;
    end else if (s1_load) begin
      s1_valid <= src_valid;
      s1_test  <= src_test;
      if (src_valid) begin
        s1_tag <= cnt;
        s1_t1  <= (~src_a | src_b) & src_c;
        s1_t2  <= (~src_b ^ src_c) & src_a;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_test  <= 1'b0;
      s2_tag   <= 3'd0;
      O        <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_test  <= s1_test;
      if (s1_valid) begin
        s2_tag <= s1_tag;
        O      <= s1_t1 ^ s1_t2;
      end
    end
  end

  assign out_valid = s2_valid & ~s2_test;
  assign chk_fail  = s2_valid & s2_test & (O != {WIDTH{F_TRUTH[s2_tag]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pass <= 1'b0;
    else if (start_ok) pass <= 1'b1;
    else if (chk_fail) pass <= 1'b0;
  end

`ifdef CIRCUIT_PIPE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_cnt <= 16'd0;
    else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_circuit_pipe.sv
// Directed bench for circuit_pipe (WIDTH=8): reset, streaming, backpressure, self-test, start filtering.
module tb_circuit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B, C, O;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       start, busy, done, pass;
`ifdef CIRCUIT_PIPE_PERF_EN
  logic [15:0] xfer_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Hand-derived: with A=F0,B=CC,C=AA lane i sees input combination i, so O is the truth table 8'h1A.
  logic [7:0] va [8] = '{8'hF0, 8'hFF, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'hFF};
  logic [7:0] vb [8] = '{8'hCC, 8'h00, 8'hFF, 8'hFF, 8'h33, 8'h00, 8'hCC, 8'h00};
  logic [7:0] vc [8] = '{8'hAA, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'hFF, 8'hAA, 8'hFF};
  logic [7:0] vo [8] = '{8'h1A, 8'hFF, 8'hFF, 8'h00, 8'h58, 8'hFF, 8'h1A, 8'h00};

  circuit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
`ifdef CIRCUIT_PIPE_PERF_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers vectors first..first+n-1 back to back; out_ready is held low for the first `hold` cycles.
  task automatic run_stream(input int first, input int n, input int hold);
    int sent = 0;
    int got  = 0;
    bit acc;
    bit refused = 0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      out_ready = (cyc >= hold);
      in_valid  = (sent < n);
      if (sent < n) begin
        A = va[first+sent];
        B = vb[first+sent];
        C = vc[first+sent];
      end
      #1;
      acc = in_valid & in_ready;
      if (in_valid && !in_ready) refused = 1;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("stream_O[%0d]", first+got), O, vo[first+got]);
          got++;
        end else begin
          chk("bp_hold_O", O, vo[first+got]);
        end
      end
      @(posedge clk);
      if (acc) sent++;
      #1;
    end
    in_valid = 0;
    chk("stream_count", got, n);
    if (hold > 0) chk("bp_refused", refused, 1);
    tick();
    chk("stream_no_dup", out_valid, 0);
  endtask

  task automatic run_selftest(input int restart_at);
    int nbusy = 0;
    bit saw_rdy = 0;
    bit saw_ov = 0;
    bit saw_done = 0;
    in_valid  = 0;
    out_ready = 0;
    start     = 1;
    #1;
    tick();
    start = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) nbusy++;
      if (in_ready) saw_rdy = 1;
      if (out_valid) saw_ov = 1;
      if (done) saw_done = 1;
      if (i == restart_at) start = 1;
      tick();
      start = 0;
    end
    chk("st_busy_cycles", nbusy, 10);
    chk("st_in_ready_busy", saw_rdy, 0);
    chk("st_out_valid_busy", saw_ov, 0);
    chk("st_done_busy", saw_done, 0);
    chk("st_done", done, 1);
    chk("st_pass", pass, 1);
    chk("st_busy_end", busy, 0);
    out_ready = 1;
  endtask

  initial begin
    rst = 1; A = 0; B = 0; C = 0;
    in_valid = 0; out_ready = 1; start = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_O", O, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    #21;
    rst = 0;
    tick();

    run_stream(0, 1, 0);
    run_stream(1, 4, 0);
    run_stream(5, 3, 4);

    run_selftest(0);
`ifdef CIRCUIT_PIPE_PERF_EN
    chk("perf_after_selftest", xfer_cnt, 8);
`endif

    // Start with s2 occupied must leave the FSM in DONE.
    out_ready = 0;
    in_valid = 1; A = 8'hFF; B = 8'h00; C = 8'h00;
    #1;
    tick();
    in_valid = 0;
    tick();
    chk("ign_s2_valid", out_valid, 1);
    start = 1;
    #1;
    tick();
    start = 0;
    chk("ign_busy", busy, 0);
    chk("ign_done", done, 1);
    out_ready = 1;
    #1;
    chk("ign_drain_O", O, 8'hFF);
    tick();
    chk("ign_drained", out_valid, 0);

    run_selftest(4);

    // Asynchronous reset with both stages full.
    out_ready = 0;
    in_valid = 1; A = 8'hFF; B = 8'h00; C = 8'h00;
    tick();
    tick();
    in_valid = 0;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_O", O, 8'hFF);
    #2;
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_O", O, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_in_ready", in_ready, 0);
    #3;
    rst = 0;
    out_ready = 1;
    tick();

    // Asynchronous reset in the middle of a sweep.
    start = 1;
    #1;
    tick();
    start = 0;
    tick();
    tick();
    chk("mid_sweep_busy", busy, 1);
    chk("mid_sweep_pass", pass, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_sweep_busy", busy, 0);
    chk("arst_sweep_pass", pass, 0);
    chk("arst_sweep_done", done, 0);
    #3;
    rst = 0;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);

`ifdef CIRCUIT_PIPE_PERF_EN
    chk("perf_rst", xfer_cnt, 0);
    out_ready = 1;
    in_valid = 1; A = 8'hF0; B = 8'hCC; C = 8'hAA;
    repeat (70010) @(posedge clk);
    #1;
    in_valid = 0;
    chk("perf_saturate", xfer_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
